// File: rtl/md_unit.sv
// md_unit -- multi-cycle multiply/divide unit with HI/LO registers.
//
// Runs mult/multu/div/divu with a fixed, parameterised latency and accepts
// mthi/mtlo writes while idle. busy and stall feed the hazard unit so that
// mf/mt/md instructions are held in D while an operation is in flight.
//
// Optional feature: define MDU_MADD_EN to add madd/maddu/msub/msubu
// (ops 7-10), which accumulate the product into the {hi,lo} value captured
// at the start of the operation.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-high reset
//   md_valid  in   op strobe, qualified by md_op
//   md_op     in   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo,
//                  7 madd, 8 maddu, 9 msub, 10 msubu (7-10 optional)
//   rs_val    in   multiplicand / dividend / mt source
//   rt_val    in   multiplier / divisor
//   hi, lo    out  HI and LO registers
//   busy      out  registered, arithmetic op in flight
//   stall     out  busy | (md_valid & arithmetic op)
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             md_valid,
  input  logic [3:0]       md_op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t               r_state;
  state_t               w_nextState;
  logic [CW-1:0]        r_cnt;
  logic [WIDTH-1:0]     r_hi, r_lo, r_a, r_b;
  logic [3:0]           r_op;
`ifdef MDU_MADD_EN
  logic [2*WIDTH-1:0]   r_acc;
`endif

  logic                 w_isArith, w_isDiv, w_start, w_finish, w_wrEn;
  logic signed [2*WIDTH-1:0] w_sProd;
  logic [2*WIDTH-1:0]   w_uProd, w_result;
  logic                 w_signedDiv, w_aNeg, w_bNeg;
  logic [WIDTH-1:0]     w_divA, w_divB, w_uQuot, w_uRem, w_quot, w_rem;

  // Classify the incoming op; undefined codes fall into the default (none).
  always_comb begin
    w_isArith = 1'b0;
    w_isDiv   = 1'b0;
    case (md_op)
      OP_MULT, OP_MULTU: w_isArith = 1'b1;
      OP_DIV, OP_DIVU: begin
        w_isArith = 1'b1;
        w_isDiv   = 1'b1;
      end
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: w_isArith = 1'b1;
`endif
      default: ;
    endcase
  end

  // Next-state logic: start only from idle, finish when the counter
  // is about to reach zero so the write lands exactly N edges after start.
  always_comb begin
    w_nextState = r_state;
    w_start     = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: if (md_valid && w_isArith) begin
        w_start     = 1'b1;
        w_nextState = S_BUSY;
      end
      S_BUSY: if (r_cnt == CW'(1)) begin
        w_finish    = 1'b1;
        w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_nextState;
  end

  // Products are formed combinationally from the captured operands; the
  // counter only delays when they are committed.
  assign w_sProd = $signed({{WIDTH{r_a[WIDTH-1]}}, r_a}) * $signed({{WIDTH{r_b[WIDTH-1]}}, r_b});
  assign w_uProd = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};

  // One unsigned divider serves both div and divu: signed division runs on
  // magnitudes and the signs are reapplied afterwards. The overflow case
  // (-2^(W-1) / -1) falls out naturally as quotient 2^(W-1), remainder 0.
  assign w_signedDiv = (r_op == OP_DIV);
  assign w_aNeg  = w_signedDiv & r_a[WIDTH-1];
  assign w_bNeg  = w_signedDiv & r_b[WIDTH-1];
  assign w_divA  = w_aNeg ? -r_a : r_a;
  assign w_divB  = w_bNeg ? -r_b : r_b;
  assign w_uQuot = (w_divB == '0) ? '0 : w_divA / w_divB;
  assign w_uRem  = (w_divB == '0) ? '0 : w_divA % w_divB;
  assign w_quot  = (w_aNeg ^ w_bNeg) ? -w_uQuot : w_uQuot;
  assign w_rem   = w_aNeg ? -w_uRem : w_uRem;

  // Select the {hi,lo} result; a zero divisor suppresses the write-back.
  always_comb begin
    w_result = {r_hi, r_lo};
    w_wrEn   = 1'b0;
    case (r_op)
      OP_MULT:  begin w_result = w_sProd; w_wrEn = 1'b1; end
      OP_MULTU: begin w_result = w_uProd; w_wrEn = 1'b1; end
      OP_DIV, OP_DIVU: begin
        w_result = {w_rem, w_quot};
        w_wrEn   = (r_b != '0);
      end
`ifdef MDU_MADD_EN
      OP_MADD:  begin w_result = r_acc + w_sProd; w_wrEn = 1'b1; end
      OP_MADDU: begin w_result = r_acc + w_uProd; w_wrEn = 1'b1; end
      OP_MSUB:  begin w_result = r_acc - w_sProd; w_wrEn = 1'b1; end
      OP_MSUBU: begin w_result = r_acc - w_uProd; w_wrEn = 1'b1; end
`endif
      default: ;
    endcase
  end

  // Datapath registers. Anything arriving while busy is ignored, including
  // mthi/mtlo, which the hazard unit should have held anyway.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_op  <= '0;
      r_cnt <= '0;
`ifdef MDU_MADD_EN
      r_acc <= '0;
`endif
    end else begin
      if (w_start) begin
        r_a   <= rs_val;
        r_b   <= rt_val;
        r_op  <= md_op;
        r_cnt <= w_isDiv ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
`ifdef MDU_MADD_EN
        r_acc <= {r_hi, r_lo};
`endif
      end else if (r_state == S_BUSY) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (r_state == S_IDLE && md_valid && md_op == OP_MTHI) r_hi <= rs_val;
      if (r_state == S_IDLE && md_valid && md_op == OP_MTLO) r_lo <= rs_val;
      if (w_finish && w_wrEn) begin
        r_hi <= w_result[2*WIDTH-1:WIDTH];
        r_lo <= w_result[WIDTH-1:0];
      end
    end
  end

  assign hi    = r_hi;
  assign lo    = r_lo;
  assign busy  = (r_state == S_BUSY);
  assign stall = busy | (md_valid & w_isArith);

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit -- scoreboard bench for md_unit. Stimulus pushes the expected
// {hi,lo} and latency of each arithmetic op; a monitor pops and compares
// whenever busy falls, and checks hi/lo hold their old values while busy.
module tb_md_unit;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          md_valid;
  logic [3:0]    md_op;
  logic [W-1:0]  rs_val, rt_val, hi, lo;
  logic          busy, stall;

  always #5 clk = ~clk;

  md_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .md_valid(md_valid), .md_op(md_op),
    .rs_val(rs_val), .rt_val(rt_val), .hi(hi), .lo(lo),
    .busy(busy), .stall(stall)
  );

  typedef struct {
    logic [63:0] oldVal;
    logic [63:0] newVal;
    int          lat;
    logic [3:0]  op;
  } exp_t;

  exp_t        sbQ[$];
  int          checks = 0;
  int          fails  = 0;
  logic [63:0] mHiLo;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit isArith(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return (op >= 4'd1 && op <= 4'd4) || (op >= 4'd7 && op <= 4'd10);
`else
    return (op >= 4'd1 && op <= 4'd4);
`endif
  endfunction

  // Reference model: MIPS semantics with plain 64-bit / int arithmetic.
  function automatic logic [63:0] modelOp(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] cur);
    logic [63:0] sp, up;
    int sa, sb;
    sp = 64'(longint'($signed(a)) * longint'($signed(b)));
    up = 64'(a) * 64'(b);
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      4'd1: return sp;
      4'd2: return up;
      4'd3: begin
        if (b == 0) return cur;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      4'd4: begin
        if (b == 0) return cur;
        return {a % b, a / b};
      end
`ifdef MDU_MADD_EN
      4'd7:  return cur + sp;
      4'd8:  return cur + up;
      4'd9:  return cur - sp;
      4'd10: return cur - up;
`endif
      default: return cur;
    endcase
  endfunction

  task automatic waitIdle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) checkOutput("idle_timeout", 64'(busy), 64'd0);
  endtask

  // Issue one op from idle; arithmetic ops go to the scoreboard, the rest
  // are checked right after the edge.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bit   arith;
    exp_t e;
    waitIdle();
    arith    = isArith(op);
    md_valid = 1'b1;
    md_op    = op;
    rs_val   = a;
    rt_val   = b;
    #1 checkOutput("stall_issue", 64'(stall), 64'(arith));
    if (arith) begin
      e.oldVal = mHiLo;
      e.newVal = modelOp(op, a, b, mHiLo);
      e.lat    = (op == 4'd3 || op == 4'd4) ? DC : MC;
      e.op     = op;
      sbQ.push_back(e);
      mHiLo = e.newVal;
    end else if (op == 4'd5) begin
      mHiLo[63:32] = a;
    end else if (op == 4'd6) begin
      mHiLo[31:0] = a;
    end
    @(posedge clk);
    #1;
    if (arith) begin
      checkOutput("busy_after_issue", 64'(busy), 64'd1);
    end else begin
      checkOutput("hilo_nonarith", {hi, lo}, mHiLo);
      checkOutput("busy_nonarith", 64'(busy), 64'd0);
    end
    @(negedge clk);
    md_valid = 1'b0;
    md_op    = 4'd0;
  endtask

  // Op issued while busy: must stall and leave everything unchanged.
  task automatic issueWhileBusy(input logic [3:0] op, input logic [31:0] a);
    md_valid = 1'b1;
    md_op    = op;
    rs_val   = a;
    #1 checkOutput("stall_while_busy", 64'(stall), 64'd1);
    @(posedge clk);
    #1 checkOutput("busy_held", 64'(busy), 64'd1);
    @(negedge clk);
    md_valid = 1'b0;
    md_op    = 4'd0;
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($signed($urandom_range(0, 18)) - 9);
      default: return $urandom;
    endcase
  endfunction

  // Monitor: counts busy cycles, checks hold behaviour, and pops the
  // scoreboard when busy falls.
  initial begin : monitor
    bit prevBusy = 1'b0;
    int cnt = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        prevBusy = 1'b0;
        cnt = 0;
      end else begin
        if (busy) begin
          cnt++;
          if (sbQ.size() > 0) checkOutput("hilo_hold", {hi, lo}, sbQ[0].oldVal);
        end else if (prevBusy) begin
          if (sbQ.size() == 0) begin
            checkOutput("unexpected_completion", 64'(cnt), 64'd0);
          end else begin
            e = sbQ.pop_front();
            checkOutput($sformatf("result_op%0d", e.op), {hi, lo}, e.newVal);
            checkOutput($sformatf("latency_op%0d", e.op), 64'(cnt), 64'(e.lat));
          end
          cnt = 0;
        end
        prevBusy = busy;
      end
    end
  end

  initial begin : stimulus
    reset    = 1'b1;
    md_valid = 1'b0;
    md_op    = 4'd0;
    rs_val   = '0;
    rt_val   = '0;
    mHiLo    = '0;
    #1;
    checkOutput("reset_hilo", {hi, lo}, 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_stall", 64'(stall), 64'd0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    applyStimulus(4'd1, 32'hFFFF_FFFF, 32'h2);
    applyStimulus(4'd2, 32'hFFFF_FFFF, 32'h2);
    applyStimulus(4'd6, 32'h1234_5678, 32'h0);
    applyStimulus(4'd3, 32'hFFFF_FFF9, 32'h2);
    applyStimulus(4'd4, 32'h7, 32'h2);
    applyStimulus(4'd5, 32'hAAAA, 32'h0);
    applyStimulus(4'd6, 32'h5555, 32'h0);
    applyStimulus(4'd3, 32'h1234, 32'h0);
    applyStimulus(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);

    // mthi on the third busy cycle of a divide must be ignored.
    applyStimulus(4'd3, 32'h64, 32'h7);
    @(negedge clk);
    issueWhileBusy(4'd5, 32'hDEAD);

    // Reset mid-multiply abandons the op with no late write-back.
    applyStimulus(4'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_reset_hilo", {hi, lo}, 64'd0);
    checkOutput("async_reset_busy", 64'(busy), 64'd0);
    sbQ.delete();
    mHiLo = '0;
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    repeat (MC + 3) @(negedge clk);
    checkOutput("no_late_write", {hi, lo}, 64'd0);
    checkOutput("no_late_busy", 64'(busy), 64'd0);

    // maddu accumulate (or no-op when the feature is compiled out).
    applyStimulus(4'd5, 32'h0, 32'h0);
    applyStimulus(4'd6, 32'hFFFF_FFFF, 32'h0);
    applyStimulus(4'd8, 32'h1, 32'h1);
    applyStimulus(4'd9, 32'h3, 32'hFFFF_FFFE);

    for (int i = 0; i < 60; i++) begin
      applyStimulus(4'($urandom_range(0, 15)), pickOperand(), pickOperand());
    end

    waitIdle();
    repeat (2) @(negedge clk);
    checkOutput("scoreboard_drained", 64'(sbQ.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit for the pipelined MIPS core. It sits in the E stage beside the ALU and owns the HI/LO registers.
- It executes mult/multu/div/divu with configurable latency and accepts mthi/mtlo writes.
- It exports busy/stall information so the hazard logic can hold mf/mt/md instructions in D.
- It is the parametrised successor of the decoder's md/mf/mt/MDU_op path: width and latencies are generic, and the unit adds real busy tracking.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for mult/multu; must be >= 1.
- DIV_CYCLES, 10, busy cycles for div/divu; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- md_valid  in  1  E-stage op strobe, qualified by md_op.
- md_op  in  4  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu (7-10 optional).
- rs_val  in  WIDTH  forwarded rs operand (multiplicand/dividend; mt source).
- rt_val  in  WIDTH  forwarded rt operand (multiplier/divisor).
- hi  out  WIDTH  current HI register, feeds mfhi.
- lo  out  WIDTH  current LO register, feeds mflo.
- busy  out  1  registered; an arithmetic op is in flight.
- stall  out  1  combinational: busy | (md_valid & md_op is arithmetic). Drives the hazard unit.

Behaviour:
- Reset: asynchronous, active-high. Clears hi, lo, busy, the cycle counter and the pending-result registers to 0 immediately, regardless of clk.
- Idle (busy=0), md_valid with an arithmetic op at edge k:
  - Latch rs_val, rt_val and op.
  - Load the counter with N = MULT_CYCLES or DIV_CYCLES.
  - busy=1 from edge k onward.
  - The counter decrements each edge. At edge k+N: hi/lo are updated with the result and busy falls on that same edge.
  - hi/lo keep their old values during cycles k..k+N-1.
- Arithmetic:
  - mult: signed 2*WIDTH product; hi=upper half, lo=lower half.
  - multu: same, unsigned.
  - div: signed; lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - divu: unsigned.
- Divide by zero (rt_val==0, div or divu): timing is unchanged (busy for DIV_CYCLES), but hi/lo are NOT written at completion.
- Signed overflow (div of -2^(WIDTH-1) by -1): lo=-2^(WIDTH-1), hi=0.
- mthi/mtlo with md_valid and busy=0: hi (or lo) <= rs_val at the same edge. No busy, stall=0.
- Any md_valid while busy=1 is ignored; state is unchanged. The hazard unit holds such instructions, so this is a protection case only.
- md_valid=0 or op 0: no effect. Undefined op codes (11-15) are treated as none.
- Operands are captured at start; changes on rs_val/rt_val during busy have no effect.
- Reset asserted mid-operation: the op is abandoned, hi/lo=0, busy=0. No late write-back occurs after reset releases.
- The internal implementation (iterative shift-subtract vs. combinational result delayed by the counter) is free, provided the cycle timing above is exact.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: ops 7-10 are accepted with MULT_CYCLES latency, computing {hi,lo} <= {hi,lo} +/- product. madd/msub use the signed product; maddu/msubu use the unsigned product. Arithmetic wraps modulo 2^(2*WIDTH). The {hi,lo} value used is the one captured at start.
- Not defined: ops 7-10 behave as none, stall stays 0 for them, and the accumulate datapath is absent.

Test Plan:
- Reset, then mult with rs=0xFFFFFFFF, rt=0x00000002 -> stall=1 in the issue cycle, busy=1 for exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- multu with the same operands -> hi=0x00000001, lo=0xFFFFFFFE after 5 cycles. Then mtlo rs=0x12345678 -> lo=0x12345678 on the next edge, busy stays 0.
- div rs=0xFFFFFFF9 (-7), rt=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu rs=7, rt=2 -> lo=3, hi=1.
- Preload hi=0xAAAA, lo=0x5555, then div rt=0 -> busy for 10 cycles, hi/lo stay 0xAAAA/0x5555. Also div 0x80000000 by 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start div, issue mthi rs=0xDEAD on cycle 3 -> mthi is ignored, and the final hi is the remainder. Start mult, assert reset on cycle 2 -> hi=lo=0, busy=0 asynchronously, with no write after release.
- With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, then maddu rs=1, rt=1 -> hi=1, lo=0 after 5 cycles. Without MDU_MADD_EN: the same stimulus leaves hi/lo unchanged and stall=0.
